search_commander: RTL and testbench

Initiator on the command side of the movement controller interface. On a `start` request, it commands a full 8-heading search sweep. During each pause window it collects person-detection scores from the vision path and tracks the best heading. It then commands the robot to orient to that heading and reports the result to the top-level mission logic.

---
 rtl/movement_pkg.sv | 24 ++
 rtl/heading_score_tracker.sv | 82 ++++++++
 rtl/search_commander.sv | 190 +++++++++++++++++++
 tb/tb_search_commander.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/movement_pkg.sv
// Shared encodings between the search commander and the movement controller.
package movement_pkg;

  localparam logic [1:0] CMD_STOP   = 2'b00;
  localparam logic [1:0] CMD_FWD    = 2'b01;
  localparam logic [1:0] CMD_BWD    = 2'b10;
  localparam logic [1:0] CMD_ORIENT = 2'b11;

  localparam logic [1:0] TURN_LEFT  = 2'b00;
  localparam logic [1:0] TURN_RIGHT = 2'b01;

  localparam logic [9:0] FULL_CIRCLE = 10'd360;
  localparam logic [9:0] HALF_CIRCLE = 10'd180;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEARCH_REQ,
    ST_SCAN,
    ST_ORIENT_REQ,
    ST_ORIENT_WAIT,
    ST_REPORT
  } search_state_t;

endpackage

// File: rtl/heading_score_tracker.sv
// Pause-window edge detect, window heading generation and running argmax of
// the detection score. The *_nxt outputs expose this cycle's update early.
module heading_score_tracker
  import movement_pkg::*;
#(
  parameter int NUM_HEADINGS = 8,
  parameter int HEADING_STEP = 45,
  parameter int SCORE_W      = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_clear,
  input  logic               i_en,
  input  logic               i_flag_A,
  input  logic               i_score_valid,
  input  logic [SCORE_W-1:0] i_score,
  output logic               o_rise,
  output logic [SCORE_W-1:0] o_best_score_nxt,
  output logic [9:0]         o_best_heading_nxt,
  output logic [SCORE_W-1:0] o_best_score,
  output logic [9:0]         o_best_heading
);

  localparam int IDX_W = $clog2(NUM_HEADINGS + 1);

  logic               r_flag_d;
  logic               r_in_win;
  logic [IDX_W-1:0]   r_win_idx;
  logic [9:0]         r_heading;
  logic [9:0]         r_best_heading;
  logic [SCORE_W-1:0] r_best_score;

  logic       w_accept;
  logic       w_in_win;
  logic       w_upd;
  logic [9:0] w_head_inc;
  logic [9:0] w_head_new;
  logic [9:0] w_cur_head;

  assign o_rise     = i_flag_A & ~r_flag_d;
  assign w_accept   = i_en & o_rise & (r_win_idx < IDX_W'(NUM_HEADINGS));
  assign w_head_inc = r_heading + 10'(HEADING_STEP);
  assign w_head_new = (w_head_inc >= FULL_CIRCLE) ? w_head_inc - FULL_CIRCLE : w_head_inc;
  // A score arriving with the rising edge belongs to the window it opens.
  assign w_cur_head = w_accept ? w_head_new : r_heading;
  assign w_in_win   = i_flag_A & (w_accept | r_in_win);
  assign w_upd      = i_en & i_score_valid & w_in_win & (i_score > r_best_score);

  assign o_best_score_nxt   = w_upd ? i_score : r_best_score;
  assign o_best_heading_nxt = w_upd ? w_cur_head : r_best_heading;
  assign o_best_score       = r_best_score;
  assign o_best_heading     = r_best_heading;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flag_d       <= 1'b0;
      r_in_win       <= 1'b0;
      r_win_idx      <= '0;
      r_heading      <= '0;
      r_best_heading <= '0;
      r_best_score   <= '0;
    end else begin
      r_flag_d <= i_flag_A;
      if (i_clear) begin
        r_in_win       <= 1'b0;
        r_win_idx      <= '0;
        r_heading      <= '0;
        r_best_heading <= '0;
        r_best_score   <= '0;
      end else if (i_en) begin
        r_win_idx      <= r_win_idx + IDX_W'(w_accept);
        r_heading      <= w_cur_head;
        r_in_win       <= w_in_win;
        r_best_heading <= o_best_heading_nxt;
        r_best_score   <= o_best_score_nxt;
      end else begin
        r_in_win <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/search_commander.sv
// Sweep / orient / report sequencer for the person search.
// SEARCH_WATCHDOG_EN compiles in the no-progress watchdog and error path.
module search_commander
  import movement_pkg::*;
#(
  parameter int NUM_HEADINGS   = 8,
  parameter int HEADING_STEP   = 45,
  parameter int SCORE_W        = 8,
  parameter int SCORE_THRESH   = 64,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               score_valid,
  input  logic [SCORE_W-1:0] person_score,
  input  logic               flag_A,
  input  logic               finish_flag_B,
  input  logic               done,
  output logic               find_person_cmd,
  output logic [1:0]         cmd,
  output logic [9:0]         orientation_cmd,
  output logic [1:0]         turn_dir,
  output logic               busy,
  output logic               result_valid,
  output logic               found,
  output logic [9:0]         best_heading,
  output logic [SCORE_W-1:0] best_score,
  output logic               error
);

  search_state_t r_state, w_state_nxt;

  logic       r_find, r_busy, r_rv, r_found;
  logic [1:0] r_cmd, r_turn;
  logic [9:0] r_orient;

  logic       w_find_nxt, w_rv_nxt, w_found_nxt;
  logic [1:0] w_cmd_nxt, w_turn_nxt;
  logic [9:0] w_orient_nxt;

  logic               w_clear;
  logic               w_wd_expire;
  logic [SCORE_W-1:0] w_score_nxt;
  logic [9:0]         w_head_nxt;

`ifdef SEARCH_WATCHDOG_EN
  logic w_rise;
`endif

  assign w_clear = (r_state == ST_IDLE) && start;

  heading_score_tracker #(
    .NUM_HEADINGS (NUM_HEADINGS),
    .HEADING_STEP (HEADING_STEP),
    .SCORE_W      (SCORE_W)
  ) u_tracker (
    .clk                (clk),
    .reset              (reset),
    .i_clear            (w_clear),
    .i_en               (r_state == ST_SCAN),
    .i_flag_A           (flag_A),
    .i_score_valid      (score_valid),
    .i_score            (person_score),
`ifdef SEARCH_WATCHDOG_EN
    .o_rise             (w_rise),
`else
    .o_rise             (),
`endif
    .o_best_score_nxt   (w_score_nxt),
    .o_best_heading_nxt (w_head_nxt),
    .o_best_score       (best_score),
    .o_best_heading     (best_heading)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_find_nxt   = 1'b0;
    w_rv_nxt     = 1'b0;
    w_cmd_nxt    = CMD_STOP;
    w_orient_nxt = r_orient;
    w_turn_nxt   = r_turn;
    w_found_nxt  = r_found;
    case (r_state)
      ST_IDLE: if (start) begin
        w_state_nxt = ST_SEARCH_REQ;
        w_find_nxt  = 1'b1;
        w_found_nxt = 1'b0;
      end
      ST_SEARCH_REQ: w_state_nxt = ST_SCAN;
      ST_SCAN: begin
        // Completion outranks the watchdog; the threshold sees this cycle's score.
        if (finish_flag_B || done) begin
          if (w_score_nxt >= SCORE_W'(SCORE_THRESH)) begin
            w_state_nxt  = ST_ORIENT_REQ;
            w_found_nxt  = 1'b1;
            w_cmd_nxt    = CMD_ORIENT;
            w_orient_nxt = w_head_nxt;
            w_turn_nxt   = (w_head_nxt <= HALF_CIRCLE) ? TURN_LEFT : TURN_RIGHT;
          end else begin
            w_state_nxt = ST_REPORT;
            w_rv_nxt    = 1'b1;
          end
        end else if (w_wd_expire) begin
          w_state_nxt = ST_REPORT;
          w_rv_nxt    = 1'b1;
          w_found_nxt = 1'b0;
        end
      end
      ST_ORIENT_REQ: w_state_nxt = ST_ORIENT_WAIT;
      ST_ORIENT_WAIT: begin
        if (done) begin
          w_state_nxt = ST_REPORT;
          w_rv_nxt    = 1'b1;
        end else if (w_wd_expire) begin
          w_state_nxt = ST_REPORT;
          w_rv_nxt    = 1'b1;
          w_found_nxt = 1'b0;
        end
      end
      ST_REPORT: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_find   <= 1'b0;
      r_busy   <= 1'b0;
      r_rv     <= 1'b0;
      r_found  <= 1'b0;
      r_cmd    <= CMD_STOP;
      r_turn   <= TURN_LEFT;
      r_orient <= '0;
    end else begin
      r_find   <= w_find_nxt;
      r_busy   <= (w_state_nxt != ST_IDLE);
      r_rv     <= w_rv_nxt;
      r_found  <= w_found_nxt;
      r_cmd    <= w_cmd_nxt;
      r_turn   <= w_turn_nxt;
      r_orient <= w_orient_nxt;
    end
  end

`ifdef SEARCH_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] r_wd;
  logic            r_error;
  logic            w_wd_run;
  logic            w_cmpl;

  assign w_wd_run    = (r_state == ST_SCAN) || (r_state == ST_ORIENT_WAIT);
  assign w_cmpl      = ((r_state == ST_SCAN) && (finish_flag_B || done)) ||
                       ((r_state == ST_ORIENT_WAIT) && done);
  assign w_wd_expire = w_wd_run && !w_rise && (r_wd == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                r_wd <= '0;
    else if (w_state_nxt != r_state || w_rise) r_wd <= '0;
    else if (w_wd_run)                        r_wd <= r_wd + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                      r_error <= 1'b0;
    else if (w_clear)               r_error <= 1'b0;
    else if (w_wd_expire && !w_cmpl) r_error <= 1'b1;
  end

  assign error = r_error;
`else
  assign w_wd_expire = 1'b0;
  assign error       = 1'b0;
`endif

  assign find_person_cmd = r_find;
  assign cmd             = r_cmd;
  assign orientation_cmd = r_orient;
  assign turn_dir        = r_turn;
  assign busy            = r_busy;
  assign result_valid    = r_rv;
  assign found           = r_found;

endmodule

// File: tb/tb_search_commander.sv
// Scoreboard bench: stimulus queues expected orient/result events, a negedge
// monitor pops and compares them whenever the DUT strobes.
module tb_search_commander;

  logic       clk = 1'b0;
  logic       reset, start, score_valid, flag_A, finish_flag_B, done;
  logic [7:0] person_score;
  logic       find_person_cmd, busy, result_valid, found, error;
  logic [1:0] cmd, turn_dir;
  logic [9:0] orientation_cmd, best_heading;
  logic [7:0] best_score;

  search_commander #(
    .NUM_HEADINGS   (8),
    .HEADING_STEP   (45),
    .SCORE_W        (8),
    .SCORE_THRESH   (64),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .score_valid     (score_valid),
    .person_score    (person_score),
    .flag_A          (flag_A),
    .finish_flag_B   (finish_flag_B),
    .done            (done),
    .find_person_cmd (find_person_cmd),
    .cmd             (cmd),
    .orientation_cmd (orientation_cmd),
    .turn_dir        (turn_dir),
    .busy            (busy),
    .result_valid    (result_valid),
    .found           (found),
    .best_heading    (best_heading),
    .best_score      (best_score),
    .error           (error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int fnd; int hd; int sc; int err; int cyc;} res_t;
  typedef struct {int hd; int td; int cyc;} or_t;

  res_t res_q[$];
  or_t  or_q[$];
  int n_chk = 0, n_fail = 0;
  int find_exp = 0, find_seen = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    res_t r;
    or_t  o;
    if (!reset) begin
      if (find_person_cmd) find_seen++;
      if (result_valid) begin
        if (res_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_result: got result_valid=1 expected 0 (cyc %0d)", cyc);
        end else begin
          r = res_q.pop_front();
          chk("res_cycle",   cyc, r.cyc);
          chk("res_found",   32'(found), r.fnd);
          chk("res_heading", 32'(best_heading), r.hd);
          chk("res_score",   32'(best_score), r.sc);
          chk("res_error",   32'(error), r.err);
        end
      end
      if (cmd == 2'b11) begin
        if (or_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_orient: got cmd=3 expected no orient (cyc %0d)", cyc);
        end else begin
          o = or_q.pop_front();
          chk("or_cycle",   cyc, o.cyc);
          chk("or_heading", 32'(orientation_cmd), o.hd);
          chk("or_turn",    32'(turn_dir), o.td);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_start();
    start = 1'b1; find_exp++;
    tick();
    start = 1'b0;
    chk("start_busy", 32'(busy), 1);
    chk("start_find", 32'(find_person_cmd), 1);
    tick();
  endtask

  task automatic window(input int s);
    flag_A = 1'b1; score_valid = 1'b1; person_score = 8'(s);
    tick();
    score_valid = 1'b0;
    tick();
    flag_A = 1'b0;
    tick();
  endtask

  task automatic finish_scan();
    finish_flag_B = 1'b1;
    tick();
    finish_flag_B = 1'b0;
  endtask

  task automatic pulse_done();
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  task automatic push_res(input int f, input int h, input int s, input int e, input int c);
    res_t r;
    r = '{f, h, s, e, c};
    res_q.push_back(r);
  endtask

  task automatic push_or(input int h, input int t, input int c);
    or_t o;
    o = '{h, t, c};
    or_q.push_back(o);
  endtask

  task automatic orient_and_finish(input int f, input int h, input int s);
    tick(); tick();
    push_res(f, h, s, 0, cyc + 1);
    pulse_done();
    tick(); tick();
    chk("back_idle", 32'(busy), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int found_sc[8];
    reset = 1'b1; start = 1'b0; score_valid = 1'b0; flag_A = 1'b0;
    finish_flag_B = 1'b0; done = 1'b0; person_score = '0;
    tick(); tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cmd", 32'(cmd), 0);
    chk("rst_outputs", 32'({find_person_cmd, result_valid, found, error, turn_dir,
                            orientation_cmd, best_heading, best_score}), 0);
    reset = 1'b0;
    tick();

    // Found: best 90 first seen in window 3 -> 135 deg, left turn
    found_sc = '{10, 20, 90, 30, 90, 5, 0, 0};
    do_start();
    foreach (found_sc[i]) window(found_sc[i]);
    push_or(135, 0, cyc + 1);
    finish_scan();
    orient_and_finish(1, 135, 90);

    // Not found (63 < 64) plus ignored out-of-window score, busy start, 9th window
    do_start();
    window(10);
    score_valid = 1'b1; person_score = 8'd255;
    tick();
    score_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    found_sc = '{63, 63, 0, 20, 1, 2, 3, 0};
    for (int i = 0; i < 7; i++) window(found_sc[i]);
    window(255);
    push_res(0, 90, 63, 0, cyc + 1);
    finish_scan();
    tick(); tick();
    chk("nf_idle", 32'(busy), 0);

    // Wrap-around: window 8 maps to heading 0
    do_start();
    for (int i = 0; i < 7; i++) window(0);
    window(200);
    push_or(0, 0, cyc + 1);
    finish_scan();
    orient_and_finish(1, 0, 200);

    // Window 5 -> 225 deg, right turn
    found_sc = '{50, 50, 50, 50, 100, 50, 50, 50};
    do_start();
    foreach (found_sc[i]) window(found_sc[i]);
    push_or(225, 1, cyc + 1);
    finish_scan();
    orient_and_finish(1, 225, 100);

    // Rise + score at exact threshold + finish on the same edge
    do_start();
    window(10);
    window(30);
    flag_A = 1'b1; score_valid = 1'b1; person_score = 8'd64; finish_flag_B = 1'b1;
    push_or(135, 0, cyc + 1);
    tick();
    flag_A = 1'b0; score_valid = 1'b0; finish_flag_B = 1'b0;
    orient_and_finish(1, 135, 64);

    // Reset in ORIENT_WAIT, then a clean restart
    do_start();
    window(100);
    push_or(45, 0, cyc + 1);
    finish_scan();
    tick(); tick();
    reset = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_outputs", 32'({find_person_cmd, result_valid, found, error, cmd, turn_dir,
                               orientation_cmd, best_heading, best_score}), 0);
    tick();
    reset = 1'b0;
    tick();
    do_start();
    push_res(0, 0, 0, 0, cyc + 1);
    finish_scan();
    tick(); tick();

    // No progress after the sweep request
    do_start();
`ifdef SEARCH_WATCHDOG_EN
    push_res(0, 0, 0, 1, cyc + 100);
    repeat (150) tick();
    chk("wd_idle", 32'(busy), 0);
`else
    repeat (1000) tick();
    chk("nowd_busy", 32'(busy), 1);
    chk("nowd_error", 32'(error), 0);
    push_res(0, 0, 0, 0, cyc + 1);
    finish_scan();
    tick(); tick();
`endif

    tick();
    chk("pending_events", 32'(res_q.size() + or_q.size()), 0);
    chk("find_pulses", find_seen, find_exp);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
